// File: rtl/ppwm_out_if.sv
// Signal bundle between the PWM output stage and its controller/execution stage.
interface ppwm_out_if #(
    parameter int COUNTER_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 4
);
    logic                      en_i;
    logic [PRESCALE_WIDTH-1:0] prescale_i;
    logic [COUNTER_WIDTH-1:0]  period_i;
    logic [COUNTER_WIDTH-1:0]  pwm_value_i;
    logic                      polarity_i;
    logic                      start_o;
    logic [COUNTER_WIDTH-1:0]  global_counter_o;
    logic                      pwm_o;

    modport master (
        output en_i, prescale_i, period_i, pwm_value_i, polarity_i,
        input  start_o, global_counter_o, pwm_o
    );

    modport slave (
        input  en_i, prescale_i, period_i, pwm_value_i, polarity_i,
        output start_o, global_counter_o, pwm_o
    );
endinterface

// File: rtl/ppwm_out.sv
// PWM output stage: prescaled period counter, shadowed duty value and a
// registered, polarity-selectable output pin.
module ppwm_out #(
    parameter int COUNTER_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    ppwm_out_if.slave bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                    r_state, w_state_nxt;
    logic [PRESCALE_WIDTH-1:0] r_presc, w_presc_nxt;
    logic [COUNTER_WIDTH-1:0]  r_cnt, w_cnt_nxt;
    logic [COUNTER_WIDTH-1:0]  r_shadow, w_shadow_nxt;
    logic                      r_start, w_start_nxt;
    logic                      r_pwm, w_pwm_nxt;
    logic                      w_tick;

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_start_nxt  = 1'b0;
        w_tick       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_presc_nxt = '0;
                w_cnt_nxt   = '0;
                if (bus.en_i) begin
                    w_state_nxt  = S_RUN;
                    w_shadow_nxt = bus.pwm_value_i;
                    w_start_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.en_i) begin
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    // >= compares let a shrunk period/prescale wrap instead of running away
                    w_tick = (r_presc >= bus.prescale_i);
                    if (w_tick) begin
                        w_presc_nxt = '0;
                        if (r_cnt >= bus.period_i) begin
                            w_cnt_nxt    = '0;
                            w_start_nxt  = 1'b1;
                            w_shadow_nxt = bus.pwm_value_i;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Built from next-state values so the pin lines up with global_counter_o
        if (w_state_nxt == S_RUN)
            w_pwm_nxt = (w_cnt_nxt < w_shadow_nxt) ^ bus.polarity_i;
        else
            w_pwm_nxt = bus.polarity_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_start  <= 1'b0;
            r_pwm    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_start  <= w_start_nxt;
            r_pwm    <= w_pwm_nxt;
        end
    end

    assign bus.start_o          = r_start;
    assign bus.global_counter_o = r_cnt;
    assign bus.pwm_o            = r_pwm;
endmodule

// File: tb/tb_ppwm_out.sv
// Directed bench for ppwm_out: vector table plus hand-written multi-cycle sequences.
module tb_ppwm_out;
    logic clk;
    logic rst;

    ppwm_out_if #(.COUNTER_WIDTH(8), .PRESCALE_WIDTH(4)) bus ();

    ppwm_out #(.COUNTER_WIDTH(8), .PRESCALE_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] pre;
        logic [7:0] per;
        logic [7:0] val;
        logic       pol;
        logic       es;
        logic [7:0] ec;
        logic       ep;
    } vec_t;

    vec_t vq[$];
    int   n_checks;
    int   n_fail;

    function automatic void add(input logic r, input logic e, input int pre, input int per,
                                input int val, input logic pol, input logic es,
                                input int ec, input logic ep);
        vec_t v;
        v.rst = r;
        v.en  = e;
        v.pre = 4'(pre);
        v.per = 8'(per);
        v.val = 8'(val);
        v.pol = pol;
        v.es  = es;
        v.ec  = 8'(ec);
        v.ep  = ep;
        vq.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input int pre, input int per, input int val,
                         input logic pol);
        bus.en_i        = e;
        bus.prescale_i  = 4'(pre);
        bus.period_i    = 8'(per);
        bus.pwm_value_i = 8'(val);
        bus.polarity_i  = pol;
    endtask

    task automatic chk(input string nm, input logic es, input int ec, input logic ep);
        n_checks++;
        if (bus.start_o !== es) begin
            n_fail++;
            $display("FAIL %s start_o: got %0b expected %0b (t=%0t)", nm, bus.start_o, es, $time);
        end
        n_checks++;
        if (bus.global_counter_o !== 8'(ec)) begin
            n_fail++;
            $display("FAIL %s global_counter_o: got %0d expected %0d (t=%0t)", nm,
                     bus.global_counter_o, ec, $time);
        end
        n_checks++;
        if (bus.pwm_o !== ep) begin
            n_fail++;
            $display("FAIL %s pwm_o: got %0b expected %0b (t=%0t)", nm, bus.pwm_o, ep, $time);
        end
    endtask

    initial begin
        int c;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b1, 0, 9, 3, 1'b1);

        // Reset has priority over enable; then idle level follows polarity
        add(1, 1, 0, 9, 3, 1, 0, 0, 0);
        add(1, 1, 0, 9, 3, 1, 0, 0, 0);
        add(0, 0, 0, 9, 3, 1, 0, 0, 1);
        add(0, 0, 0, 9, 3, 0, 0, 0, 0);
        // Basic period: 10 counts, high for 0..2
        for (int k = 0; k < 12; k++) begin
            c = k % 10;
            add(0, 1, 0, 9, 3, 0, c == 0, c, c < 3);
        end
        add(0, 0, 0, 9, 3, 0, 0, 0, 0);
        // Prescale 1, inverted polarity: each count lasts two cycles
        add(0, 0, 1, 9, 3, 1, 0, 0, 1);
        for (int k = 0; k < 21; k++) begin
            c = (k / 2) % 10;
            add(0, 1, 1, 9, 3, 1, (k % 20) == 0, c, !(c < 3));
        end
        add(0, 0, 1, 9, 3, 1, 0, 0, 1);
        // Duty 0: constant inactive
        for (int k = 0; k < 12; k++) begin
            c = k % 10;
            add(0, 1, 0, 9, 0, 0, c == 0, c, 0);
        end
        add(0, 0, 0, 9, 0, 0, 0, 0, 0);
        // Duty above period: constant active across the wrap
        for (int k = 0; k < 12; k++) begin
            c = k % 10;
            add(0, 1, 0, 9, 12, 0, c == 0, c, 1);
        end
        add(0, 0, 0, 9, 12, 0, 0, 0, 0);
        // Full-width period: 256 counts, no overflow
        for (int k = 0; k < 258; k++) begin
            c = k % 256;
            add(0, 1, 0, 255, 255, 0, c == 0, c, c < 255);
        end
        add(0, 0, 0, 9, 3, 0, 0, 0, 0);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            drive(vq[i].en, int'(vq[i].pre), int'(vq[i].per), int'(vq[i].val), vq[i].pol);
            step();
            chk($sformatf("vec%0d", i), vq[i].es, int'(vq[i].ec), vq[i].ep);
        end

        // Shadow update: value changes 3->7 at count 5
        drive(1'b1, 0, 9, 3, 1'b0);
        step();
        chk("shadow_start", 1, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("shadow_p1", 0, k, k < 3);
        end
        bus.pwm_value_i = 8'd7;
        for (int k = 6; k < 30; k++) begin
            c = k % 10;
            step();
            chk("shadow_run", c == 0, c, (k < 10) ? (c < 3) : (c < 7));
        end
        bus.en_i = 1'b0;
        step();
        chk("shadow_idle", 0, 0, 0);

        // Period shrink 9->5 at count 8
        drive(1'b1, 0, 9, 3, 1'b0);
        step();
        chk("shrink_start", 1, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("shrink_p1", 0, k, k < 3);
        end
        bus.period_i = 8'd5;
        for (int j = 0; j < 13; j++) begin
            c = j % 6;
            step();
            chk("shrink_run", c == 0, c, c < 3);
        end
        bus.en_i = 1'b0;
        step();
        chk("shrink_idle", 0, 0, 0);

        // Prescale shrink 3->1 while prescaler sits at 2
        drive(1'b1, 3, 9, 3, 1'b0);
        step();
        chk("pshrink_start", 1, 0, 1);
        step();
        chk("pshrink_p1", 0, 0, 1);
        step();
        chk("pshrink_p2", 0, 0, 1);
        bus.prescale_i = 4'd1;
        step();
        chk("pshrink_wrap", 0, 1, 1);
        step();
        chk("pshrink_hold", 0, 1, 1);
        step();
        chk("pshrink_next", 0, 2, 1);
        bus.en_i = 1'b0;
        step();
        chk("pshrink_idle", 0, 0, 0);

        // Abort by en_i at count 4, then restart
        drive(1'b1, 0, 9, 6, 1'b0);
        step();
        chk("abort_start", 1, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("abort_run", 0, k, 1);
        end
        bus.en_i = 1'b0;
        step();
        chk("abort_idle", 0, 0, 0);
        bus.en_i = 1'b1;
        step();
        chk("abort_restart", 1, 0, 1);
        step();
        chk("abort_cnt1", 0, 1, 1);

        // Reset at count 4 while enabled, then restart
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("rst_run", 0, k, 1);
        end
        rst = 1'b1;
        step();
        chk("rst_abort", 0, 0, 0);
        rst = 1'b0;
        step();
        chk("rst_restart", 1, 0, 1);
        step();
        chk("rst_cnt1", 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
